// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
// Ports (signals):
//   imem_req   fetch request (fetch unit -> memory)
//   imem_addr  32-bit fetch address (fetch unit -> memory)
//   imem_ready memory accepts/returns the word this cycle (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;

    modport master (output imem_req, output imem_addr, input imem_ready);
    modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer for the RV32I core.
// Owns the PC, drives the instruction-memory request, and produces IF/ID valid
// and flush controls. Branch (EX) redirects take priority over jumps (ID).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- misaligned redirect targets
// go to TRAP_VECTOR and pulse `misaligned`; otherwise target[1:0] is cleared.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall               hazard hold: freezes PC and IF/ID outputs
//   branch_taken/target branch redirect from EX
//   jump/jump_target    JAL/JALR redirect from ID
//   imem                master side of the instruction-memory request bus
//   if_pc, if_valid     PC and valid of the instruction latched into IF/ID
//   flush               kill IF/ID and ID/EX
//   misaligned          one-cycle pulse for a misaligned redirect target
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [31:0]            jump_target,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            if_pc,
    output logic                   if_valid,
    output logic                   flush,
    output logic                   misaligned
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        req_q;
    logic        flush_q;
    logic        mis_q, mis_d;

    logic        redirect;
    logic        accept;
    logic [31:0] target_raw;
    logic [31:0] target_sel;
    logic        target_bad;

    assign redirect   = branch_taken | jump;
    assign accept     = req_q & imem.imem_ready & ~stall;
    // Branch is older than the jump in ID, so it wins.
    assign target_raw = branch_taken ? branch_target : jump_target;
    assign target_bad = (target_raw[1:0] != 2'b00);

    // Redirect target legalisation: trap or force word alignment.
    always_comb begin
        target_sel = {target_raw[31:2], 2'b00};
        if (TRAP_EN && target_bad) begin
            target_sel = TRAP_VECTOR;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC and IF/ID update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        mis_d      = 1'b0;

        if (redirect) begin
            // Honoured in every state and through stall; any same-cycle accept is dropped.
            state_d    = REDIRECT;
            pc_d       = target_sel;
            if_valid_d = 1'b0;
            mis_d      = TRAP_EN & target_bad;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d    = FETCH;
                    if_valid_d = 1'b0;
                end
                FETCH: begin
                    if (accept) begin
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
                REDIRECT: begin
                    state_d    = FETCH;
                    if_valid_d = 1'b0;
                end
                default: begin
                    state_d    = BOOT;
                    if_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and registered outputs; req/flush are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            if_pc_q    <= 32'h0000_0000;
            if_valid_q <= 1'b0;
            req_q      <= 1'b0;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            req_q      <= (state_d == FETCH);
            flush_q    <= (state_d == REDIRECT);
            mis_q      <= mis_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_pc          = if_pc_q;
    assign if_valid       = if_valid_q;
    assign flush          = flush_q;
    assign misaligned     = mis_q;

endmodule
